out_uart_streamer: RTL
======================

OUT_UART_STREAMER -- requirements
Module: out_uart_streamer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, giving clock cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving byte FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ena  input  1  capture enable; high while the upstream user design is selected.
REQ-006 SHALL have port data_in  input  8  upstream uo_out bus value.
REQ-007 SHALL have port push  input  1  force-enqueue strobe, one cycle.
REQ-008 SHALL have port overflow_clr  input  1  clears the sticky overflow flag.
REQ-009 SHALL have port tx  output  1  UART 8N1 serial output, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is being sent.
REQ-011 SHALL have port overflow  output  1  sticky: an enqueue was dropped.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-013 SHALL hold an 8-bit last-value register last_q.
REQ-014 SHALL generate an enqueue request in any cycle with ena=1 and either data_in != last_q or push=1.
REQ-015 SHALL load last_q with data_in on every cycle with ena=1, including cycles where the enqueue is dropped.
REQ-016 SHALL generate no enqueue and leave last_q unchanged while ena=0, regardless of push.
REQ-017 SHALL implement the FIFO as a circular buffer whose read and write pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL make fifo_count update on the edge after an enqueue or dequeue.
REQ-019 SHALL drop an enqueue when the FIFO is full with no dequeue in the same cycle, and set overflow.
REQ-020 SHALL accept an enqueue when the FIFO is full and a dequeue occurs in the same cycle, leaving fifo_count unchanged.
REQ-021 SHALL, on a simultaneous enqueue and dequeue at any other count, leave fifo_count unchanged.
REQ-022 SHALL clear overflow on overflow_clr=1; when a set and a clear occur in the same cycle, the set SHALL win.
REQ-023 SHALL implement transmit FSM states IDLE, START, DATA and STOP.
REQ-024 SHALL, in IDLE with fifo_count>0, pop the head byte into a shift register and go to START.
REQ-025 SHALL drive tx=0 in START for CLKS_PER_BIT cycles.
REQ-026 SHALL, in DATA, send 8 bits LSB first for CLKS_PER_BIT cycles each.
REQ-027 SHALL drive tx=1 in STOP for CLKS_PER_BIT cycles, then return to IDLE.
REQ-028 SHALL send a full frame in exactly 10*CLKS_PER_BIT cycles.
REQ-029 SHALL allow IDLE to pop on its first cycle, so back-to-back frames are separated by exactly 1 idle cycle of tx=1.
REQ-030 SHALL register tx, with busy = (state != IDLE).
REQ-031 SHALL meet this latency from an empty, idle state: data_in change sampled at edge k -> fifo_count=1 after edge k -> tx falls after edge k+1.
REQ-032 SHALL NOT let later changes to data_in alter a byte once it is enqueued.

Reset
REQ-033 SHALL, while rst=1 at an edge, set tx=1, busy=0, overflow=0, fifo_count=0, last_q=8'h00, pointers=0 and state=IDLE.
REQ-034 SHALL, on reset mid-frame, abandon the frame, drive tx=1 after that edge and discard all queued bytes.
REQ-035 SHALL NOT enqueue in a cycle with rst=1.

Verification
REQ-036 Single byte: CLKS_PER_BIT=4, ena=1, data_in 00->A5 -> tx falls 2 edges later; bits 1,0,1,0,0,1,0,1, each 4 cycles; stop high; busy high for 40 cycles.
REQ-037 Repeat push: data_in held at 3C, push pulsed twice 1 cycle apart -> two 3C frames, 41 cycles from the first start edge to the second start edge.
REQ-038 Overflow: 6 distinct bytes on consecutive cycles, FIFO_DEPTH=4 -> first 5 sent (1 in the shift register, 4 queued), 6th dropped, overflow=1 until overflow_clr; simultaneous set and clear leaves overflow=1.
REQ-039 Gating: ena=0 while data_in toggles and push pulses -> no frames, fifo_count=0; on raising ena with data_in equal to last_q -> no frame.
REQ-040 Reset mid-frame: rst asserted during DATA -> after the next edge tx=1, busy=0, fifo_count=0, overflow=0; next change of data_in away from 00 produces a clean frame.

Source files
------------

// File: rtl/out_uart_streamer.sv
// Captures changes on an 8-bit output bus into a small byte FIFO and streams
// each byte out as a UART 8N1 frame.
module out_uart_streamer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [7:0]                    data_in,
  input  logic                          push,
  input  logic                          overflow_clr,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    last_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [TW-1:0] clk_cnt_q;
  logic [TW-1:0] clk_cnt_d;
  logic [2:0]    bit_cnt_q;
  logic [2:0]    bit_cnt_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          tx_q;
  logic          tx_d;
  logic          busy_q;

  logic enq_req;
  logic full;
  logic deq;
  logic enq_ok;
  logic ovf_set;

  // Enqueue on any bus change or forced push while selected; a full FIFO
  // still accepts when the transmitter pops in the same cycle.
  assign enq_req = ena & ~rst & ((data_in != last_q) | push);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign enq_ok  = enq_req & (~full | deq);
  assign ovf_set = enq_req & full & ~deq;

  always_comb begin
    count_d = count_q;
    case ({enq_ok, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM next-state and bit timing
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    deq       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        clk_cnt_d = '0;
        if (count_q != '0) begin
          deq     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + TW'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + TW'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (enq_ok) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      if (ena)    last_q   <= data_in;
      if (enq_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (deq)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (ovf_set)           ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule
